// File: rtl/display_pkg.sv
// Shared seven-segment encoding for the multiplexed display drivers.
// Table entries are active-low gfedcba, nibble 0 in the least significant slot.
package display_pkg;

   localparam logic [111:0] SEG_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b0100111,  // c
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0011000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   function automatic logic [6:0] seg_of(input logic [3:0] nibble);
      logic [6:0] base_s;
      base_s = 7'(nibble) * 7'd7;
      return SEG_TABLE[base_s +: 7];
   endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot counter and digit index for the multiplexed scan; flags the frame wrap
// and the dead-time window (DISPLAY_NHEX_GHOST_BLANK_EN enables the window).
module display_scan_timer #(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 2048,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_wrap,
   output logic                          blank_win
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(DIGIT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
`ifdef DISPLAY_NHEX_GHOST_BLANK_EN
   localparam bit GHOST_EN = 1'b1;
`else
   localparam bit GHOST_EN = 1'b0;
`endif

   logic [CW-1:0] cnt_r;
   logic [IW-1:0] idx_r;

   // Dwell counter; each terminal count steps to the next digit to the right.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_r <= '0;
         idx_r <= IDX_LAST;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
         idx_r <= (idx_r == '0) ? IDX_LAST : idx_r - IW'(1);
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   // Status decoded from the counter state.
   always_comb begin
      digit_idx  = idx_r;
      frame_wrap = (cnt_r == CNT_LAST) && (idx_r == '0);
      blank_win  = GHOST_EN && (cnt_r < BLANK_END);
   end

endmodule

// File: rtl/display_nhex_scan.sv
// N-digit multiplexed hex display driver with double-buffered load handshake,
// leading-zero blanking and optional slot dead-time (DISPLAY_NHEX_GHOST_BLANK_EN).
module display_nhex_scan
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 2048,
   parameter int ACTIVE_LOW   = 1,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     digit_en_in,
   input  logic                      blank_lz_in,
   input  logic                      load_valid_in,
   output logic                      load_ready_out,
   output logic [6:0]                seg_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     strobe_out,
   output logic                      frame_out
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic POL = (ACTIVE_LOW != 0);

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] data;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   en;
      logic                    lz;
   } disp_frame_t;

   localparam disp_frame_t FRAME_RST = '{data: '0, dp: '0, en: '1, lz: 1'b0};

   // Bit k set when nibbles NUM_DIGITS-1 down to k are all zero; digit 0 never set.
   function automatic logic [NUM_DIGITS-1:0] zero_run(input logic [4*NUM_DIGITS-1:0] data);
      logic run;
      zero_run = '0;
      run      = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         run         = run && (data[4*k +: 4] == 4'h0);
         zero_run[k] = run;
      end
   endfunction

   logic [IW-1:0]         idx_s;
   logic                  wrap_s;
   logic                  blank_s;
   logic                  accept_s;
   disp_frame_t           pend_r;
   disp_frame_t           disp_r;
   logic                  pend_full_r;
   logic                  ready_r;
   logic                  frame_r;
   logic [NUM_DIGITS-1:0] zrun_r;
   logic [3:0]            nib_s;
   logic                  en_s;
   logic                  dpb_s;
   logic                  lzb_s;
   logic [NUM_DIGITS-1:0] onehot_s;
   logic [6:0]            seg_hi_s;
   logic                  dp_hi_s;
   logic [NUM_DIGITS-1:0] stb_hi_s;
   logic [6:0]            seg_r;
   logic                  dp_r;
   logic [NUM_DIGITS-1:0] strobe_r;

   display_scan_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .DIGIT_CYCLES(DIGIT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .digit_idx (idx_s),
      .frame_wrap(wrap_s),
      .blank_win (blank_s)
   );

   assign accept_s = load_valid_in && ready_r;

   // Pending capture, frame-boundary commit and ready handshake.
   // Ready stays low through the frame_out cycle so a commit is never overlapped by a load.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pend_r      <= FRAME_RST;
         disp_r      <= FRAME_RST;
         pend_full_r <= 1'b0;
         ready_r     <= 1'b1;
         frame_r     <= 1'b0;
         zrun_r      <= '0;
      end else begin
         frame_r <= wrap_s;
         if (accept_s) begin
            pend_r      <= '{data: data_in, dp: dp_in, en: digit_en_in, lz: blank_lz_in};
            pend_full_r <= 1'b1;
            ready_r     <= 1'b0;
         end else if (frame_r) begin
            ready_r <= 1'b1;
         end
         if (wrap_s && pend_full_r) begin
            disp_r      <= pend_r;
            zrun_r      <= zero_run(pend_r.data);
            pend_full_r <= 1'b0;
         end
      end
   end

   // Active-high drive for the digit currently selected by the timer.
   always_comb begin
      nib_s           = disp_r.data[{idx_s, 2'b00} +: 4];
      en_s            = disp_r.en[idx_s];
      dpb_s           = disp_r.dp[idx_s];
      lzb_s           = disp_r.lz && zrun_r[idx_s];
      onehot_s        = '0;
      onehot_s[idx_s] = 1'b1;
      seg_hi_s        = 7'h00;
      dp_hi_s         = 1'b0;
      stb_hi_s        = '0;
      if (blank_s || !en_s) begin
         stb_hi_s = '0;
      end else if (!lzb_s) begin
         stb_hi_s = onehot_s;
         seg_hi_s = ~seg_of(nib_s);
         dp_hi_s  = dpb_s;
      end else if (dpb_s) begin
         stb_hi_s = onehot_s;
         dp_hi_s  = 1'b1;
      end else begin
         stb_hi_s = '0;
      end
   end

   // Output registers with board polarity applied.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         seg_r    <= {7{POL}};
         dp_r     <= POL;
         strobe_r <= {NUM_DIGITS{POL}};
      end else begin
         seg_r    <= seg_hi_s ^ {7{POL}};
         dp_r     <= dp_hi_s ^ POL;
         strobe_r <= stb_hi_s ^ {NUM_DIGITS{POL}};
      end
   end

   assign seg_out        = seg_r;
   assign dp_out         = dp_r;
   assign strobe_out     = strobe_r;
   assign frame_out      = frame_r;
   assign load_ready_out = ready_r;

endmodule

// File: tb/tb_display_nhex_scan.sv
// Self-checking bench for display_nhex_scan (4 digits, 8-cycle dwell, active-low).
module tb_display_nhex_scan;

   localparam int NUMD  = 4;
   localparam int DCYC  = 8;
   localparam int BLANK = 2;
`ifdef DISPLAY_NHEX_GHOST_BLANK_EN
   localparam bit GHOST = 1'b1;
`else
   localparam bit GHOST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data_in = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  digit_en_in = 4'hF;
   logic        blank_lz_in = 1'b0;
   logic        load_valid_in = 1'b0;
   logic        load_ready_out;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  strobe_out;
   logic        frame_out;

   int total = 0;
   int bad = 0;
   logic chk_en = 1'b0;

   display_nhex_scan #(
      .NUM_DIGITS(NUMD), .DIGIT_CYCLES(DCYC), .ACTIVE_LOW(1), .BLANK_CYCLES(BLANK)
   ) dut (
      .clk_in(clk), .rst_n_in(rst_n), .data_in(data_in), .dp_in(dp_in),
      .digit_en_in(digit_en_in), .blank_lz_in(blank_lz_in),
      .load_valid_in(load_valid_in), .load_ready_out(load_ready_out),
      .seg_out(seg_out), .dp_out(dp_out), .strobe_out(strobe_out), .frame_out(frame_out)
   );

   always #5 clk = ~clk;

   logic [6:0] lut [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011, 7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Model: displayed/pending frames, handshake and time since reset release.
   int          cyc;
   logic [15:0] m_data, p_data;
   logic [3:0]  m_dp, m_en, p_dp, p_en;
   logic        m_lz, p_lz, p_full, m_ready;
   logic [6:0]  e_seg;
   logic        e_dp, e_frame;
   logic [3:0]  e_st;

   function automatic logic [11:0] drive(input int dig, input int cnt);
      logic [6:0] s;
      logic       d;
      logic [3:0] st;
      logic       lzb;
      s   = 7'h7F;
      d   = 1'b1;
      st  = 4'hF;
      lzb = m_lz && (dig > 0) && ((m_data >> (dig * 4)) == 16'h0);
      if (!(GHOST && cnt < BLANK) && m_en[dig]) begin
         if (!lzb) begin
            st[dig] = 1'b0;
            s = lut[m_data[dig*4 +: 4]];
            d = !m_dp[dig];
         end else if (m_dp[dig]) begin
            st[dig] = 1'b0;
            d = 1'b0;
         end
      end
      return {s, d, st};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= 0;
         m_data <= 16'h0; m_dp <= 4'h0; m_en <= 4'hF; m_lz <= 1'b0;
         p_data <= 16'h0; p_dp <= 4'h0; p_en <= 4'hF; p_lz <= 1'b0;
         p_full <= 1'b0; m_ready <= 1'b1; e_frame <= 1'b0;
         e_seg <= 7'h7F; e_dp <= 1'b1; e_st <= 4'hF;
      end else begin
         {e_seg, e_dp, e_st} <= drive(NUMD - 1 - ((cyc / DCYC) % NUMD), cyc % DCYC);
         e_frame <= ((cyc % (NUMD * DCYC)) == NUMD * DCYC - 1);
         if (e_frame) m_ready <= 1'b1;
         if (load_valid_in && m_ready) begin
            p_data <= data_in; p_dp <= dp_in; p_en <= digit_en_in; p_lz <= blank_lz_in;
            p_full <= 1'b1; m_ready <= 1'b0;
         end
         if (((cyc % (NUMD * DCYC)) == NUMD * DCYC - 1) && p_full) begin
            m_data <= p_data; m_dp <= p_dp; m_en <= p_en; m_lz <= p_lz;
            p_full <= 1'b0;
         end
         cyc <= cyc + 1;
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("seg", {25'h0, seg_out}, {25'h0, e_seg});
         check("dp", {31'h0, dp_out}, {31'h0, e_dp});
         check("strobe", {28'h0, strobe_out}, {28'h0, e_st});
         check("frame", {31'h0, frame_out}, {31'h0, e_frame});
         check("ready", {31'h0, load_ready_out}, {31'h0, m_ready});
      end
   end

   task automatic wait_frame(input string nm);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (frame_out) begin
            found = 1'b1;
            break;
         end
      end
      check(nm, {31'h0, found}, 32'd1);
   endtask

   task automatic show(input string nm, input logic [3:0] st, input logic [6:0] sg);
      check({nm, "_strobe"}, {28'h0, strobe_out}, {28'h0, st});
      check({nm, "_seg"}, {25'h0, seg_out}, {25'h0, sg});
   endtask

   // Loads one frame, then waits for its commit; leaves the bench at digit 3, count 2.
   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e, input logic l);
      wait_frame("pre_load_frame");
      @(negedge clk);
      check("ready_before_load", {31'h0, load_ready_out}, 32'd1);
      data_in = d; dp_in = p; digit_en_in = e; blank_lz_in = l; load_valid_in = 1'b1;
      @(negedge clk);
      load_valid_in = 1'b0;
      check("ready_drop", {31'h0, load_ready_out}, 32'd0);
      wait_frame("commit_frame");
      check("commit_ready_low", {31'h0, load_ready_out}, 32'd0);
      @(negedge clk);
      check("ready_rise", {31'h0, load_ready_out}, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc;
      logic found;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      show("reset", 4'hF, 7'h7F);
      check("reset_ready", {31'h0, load_ready_out}, 32'd1);
      check("reset_frame", {31'h0, frame_out}, 32'd0);
      rst_n = 1'b1;

      // 1: idle scan of zeros
      repeat (3) @(negedge clk);
      show("t1_d3", 4'b0111, 7'b1000000);
      repeat (8) @(negedge clk);
      show("t1_d2", 4'b1011, 7'b1000000);
      wait_frame("t1_frame");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_out && n < 80);
      check("t1_frame_period", n, 32'd32);

      // 2: 12AF with dp on digit 2
      do_load(16'h12AF, 4'b0100, 4'hF, 1'b0);
      show("t2_d3", 4'b0111, 7'b1111001);
      check("t2_d3_dp", {31'h0, dp_out}, 32'd1);
      repeat (8) @(negedge clk);
      show("t2_d2", 4'b1011, 7'b0100100);
      check("t2_d2_dp", {31'h0, dp_out}, 32'd0);
      repeat (8) @(negedge clk);
      show("t2_d1", 4'b1101, 7'b0001000);
      repeat (8) @(negedge clk);
      show("t2_d0", 4'b1110, 7'b0001110);

      // 3: leading-zero blanking
      do_load(16'h0030, 4'b0000, 4'hF, 1'b1);
      show("t3_d3", 4'hF, 7'h7F);
      repeat (8) @(negedge clk);
      show("t3_d2", 4'hF, 7'h7F);
      repeat (8) @(negedge clk);
      show("t3_d1", 4'b1101, 7'b0110000);
      repeat (8) @(negedge clk);
      show("t3_d0", 4'b1110, 7'b1000000);
      do_load(16'h0000, 4'b0000, 4'hF, 1'b1);
      show("t3z_d3", 4'hF, 7'h7F);
      repeat (16) @(negedge clk);
      show("t3z_d1", 4'hF, 7'h7F);
      repeat (8) @(negedge clk);
      show("t3z_d0", 4'b1110, 7'b1000000);
      do_load(16'h0040, 4'b0100, 4'hF, 1'b1);
      repeat (8) @(negedge clk);
      show("t3dp_d2", 4'b1011, 7'h7F);
      check("t3dp_d2_dp", {31'h0, dp_out}, 32'd0);

      // 4: per-digit enable
      do_load(16'h5678, 4'b0000, 4'b1010, 1'b0);
      show("t4_d3", 4'b0111, 7'b0010010);
      repeat (8) @(negedge clk);
      show("t4_d2", 4'hF, 7'h7F);
      repeat (8) @(negedge clk);
      show("t4_d1", 4'b1101, 7'b1111000);
      repeat (8) @(negedge clk);
      show("t4_d0", 4'hF, 7'h7F);

      // 5: valid held high with changing data
      digit_en_in = 4'hF;
      blank_lz_in = 1'b0;
      wait_frame("t5_start");
      @(negedge clk);
      load_valid_in = 1'b1;
      for (int f = 0; f < 3; f++) begin
         acc = 0;
         found = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (load_valid_in && load_ready_out) acc++;
            if (frame_out) begin
               check("t5_commit_ready", {31'h0, load_ready_out}, 32'd0);
               found = 1'b1;
               break;
            end
            data_in = data_in + 16'h1111;
            dp_in = dp_in + 4'h1;
            @(negedge clk);
         end
         check("t5_frame_seen", {31'h0, found}, 32'd1);
         check("t5_accepts", acc, 32'd1);
         @(negedge clk);
      end
      load_valid_in = 1'b0;
      dp_in = 4'h0;

      // 6: reset mid-slot with pending full
      wait_frame("t6_start");
      @(negedge clk);
      data_in = 16'hBEEF;
      load_valid_in = 1'b1;
      @(negedge clk);
      load_valid_in = 1'b0;
      check("t6_pending", {31'h0, load_ready_out}, 32'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      show("t6_async", 4'hF, 7'h7F);
      check("t6_async_dp", {31'h0, dp_out}, 32'd1);
      check("t6_async_ready", {31'h0, load_ready_out}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      show("t6_d3", 4'b0111, 7'b1000000);
      wait_frame("t6_frame1");
      wait_frame("t6_frame2");
      repeat (3) @(negedge clk);
      show("t6_post_d3", 4'b0111, 7'b1000000);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
